inst_cache: RTL and testbench
=============================

Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache in the IF stage of the Harvard pipelined CPU. It sits between the PC and instruction memory.
- On a hit it returns the 16-bit instruction in the same cycle.
- On a miss it fetches a 4-word line from instruction memory through a request/acknowledge handshake, and raises InstCacheBusy for the whole refill. The pipeline control unit consumes InstCacheBusy to stall PC and IF/ID.

Parameters:
- INDEX_BITS, 2, log2 of the number of lines. Tag width = 16 - 2 - INDEX_BITS.
- WORD_WIDTH, 16, instruction and address width. Fixed at 16; the parameter exists for documentation only.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ReadEn  in  1  IF stage requests a fetch at PC this cycle.
- PC  in  16  fetch address (word address). PC[1:0] is the word offset, PC[INDEX_BITS+1:2] is the index, the upper bits are the tag.
- FetchTaken  in  1  IF/ID latched the returned word this cycle (PCWrite from control). Used for statistics only.
- Inst  out  16  instruction word; valid when InstValid=1.
- InstValid  out  1  ReadEn && hit && state==IDLE.
- InstCacheBusy  out  1  stall request to control.
- MemReadReq  out  1  line-fill request to instruction memory.
- MemAddr  out  14  line address of the request ({tag,index}).
- MemAck  in  1  one-cycle pulse; MemData is valid in that cycle.
- MemData  in  64  line data; word k is MemData[16k+15:16k].
- HitCount  out  16  saturating count of taken hits.
- MissCount  out  16  saturating count of refills started.

Behaviour:
- Storage per line: valid bit, tag, 64-bit data. Reset clears all valid bits; the data and tag arrays are not reset.
- Hit rule: valid[index] && tag[index]==PC tag. Hit detection is combinational on PC. Inst = selected word of the line. In IDLE, Inst is don't-care when InstValid=0.
- FSM states are IDLE, WAIT and FILL.
- IDLE:
  - InstCacheBusy = ReadEn && !hit, combinational.
  - On ReadEn && !hit, latch MissLine={tag,index} and go to WAIT; MissCount += 1, saturating at 16'hFFFF.
  - ReadEn=0 means no request and no busy.
- WAIT:
  - MemReadReq=1 (registered, asserted from the first WAIT cycle) and MemAddr=MissLine, held stable until MemAck.
  - InstCacheBusy=1 and InstValid=0.
  - On MemAck: write MemData, tag and valid=1 into line MissLine index, deassert MemReadReq next cycle, go to FILL.
- FILL: one cycle with InstCacheBusy=1, MemReadReq=0 and InstValid=0; then go to IDLE.
- Miss latency: IDLE miss cycle, then N WAIT cycles (ack in the Nth), then 1 FILL cycle. InstCacheBusy is high for N+2 cycles, and the hit is seen in the following IDLE cycle.
- PC change during a refill (branch or jump misprediction redirect): the refill completes to the latched MissLine regardless of PC. Back in IDLE, the lookup is re-evaluated against the current PC and may miss again.
- ReadEn dropping during WAIT/FILL: the refill still completes.
- MemAck outside WAIT is ignored: no write and no state change.
- HitCount += 1, saturating, when state==IDLE && ReadEn && hit && FetchTaken. A hit repeated while FetchTaken=0 (data-cache stall) is not counted.
- Reset asserted mid-refill: immediately go to IDLE, MemReadReq=0, valid bits cleared, counters set to 0. A late MemAck after reset is ignored.
- Reset values: MemReadReq=0, MemAddr=0, HitCount=0, MissCount=0, state IDLE. InstValid and InstCacheBusy follow their IDLE equations.

Test Plan:
1. Cold miss: after reset, ReadEn=1, PC=16'h0005, memory acks 3 cycles after MemReadReq rises with MemData=64'h4444_3333_2222_1111.
   - Required: MemAddr=14'h0001 and InstCacheBusy high for 5 cycles.
   - Then InstValid=1, Inst=16'h2222, and MissCount=1.
2. Line reuse: after test 1, PC=16'h0004, 16'h0006, 16'h0007 with FetchTaken=1.
   - Required: same-cycle hits, Inst=1111/3333/4444, Busy=0 throughout, HitCount=4 in total (the refill hit plus 3).
3. Conflict eviction: with INDEX_BITS=2, fetch PC=16'h0010, then PC=16'h0000.
   - Required: both are misses (same index 0), and MissCount increments twice.
   - After the second fill, PC=16'h0010 misses again.
4. Redirect mid-refill: miss on PC=16'h0020, change PC to 16'h0044 during WAIT.
   - Required: line 14'h0008 is filled, then a second miss is issued with MemAddr=14'h0011 and no spurious InstValid between them.
5. Stall accounting: hit held for 4 cycles with FetchTaken=0, then 1 cycle with FetchTaken=1.
   - Required: HitCount increments by exactly 1.
6. Reset mid-refill: assert reset_n=0 during WAIT, release it, then pulse MemAck.
   - Required: MemReadReq=0 immediately and the stray ack is ignored.
   - The next fetch of the same PC misses, and counters restart from 0.

Source files
------------

// File: rtl/inst_cache_if.sv
// Line-fill port between the instruction cache and instruction memory.
//
// Handshake: the cache raises MemReadReq and holds MemAddr stable until
// memory answers with a single-cycle MemAck. MemData carries the whole
// 4-word line in that same cycle. The request drops on the cycle after the
// ack, and MemAck is ignored unless a request is outstanding.
interface inst_cache_if;
  logic        MemReadReq;
  logic [13:0] MemAddr;
  logic        MemAck;
  logic [63:0] MemData;

  modport master (
    output MemReadReq,
    output MemAddr,
    input  MemAck,
    input  MemData
  );

  modport slave (
    input  MemReadReq,
    input  MemAddr,
    output MemAck,
    output MemData
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache for the IF stage.
// Hits return the instruction combinationally from PC. A miss refills a
// 4-word line from instruction memory while InstCacheBusy stalls the pipe.
module inst_cache #(
  parameter int INDEX_BITS = 2,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ReadEn,
  input  logic [WORD_WIDTH-1:0] PC,
  input  logic                  FetchTaken,
  output logic [WORD_WIDTH-1:0] Inst,
  output logic                  InstValid,
  output logic                  InstCacheBusy,
  output logic [15:0]           HitCount,
  output logic [15:0]           MissCount,
  output logic [1:0]            state_dbg,
  inst_cache_if.master          mem
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 14 - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FILL = 2'd2
  } state_t;

  // Control state
  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [13:0]       miss_line_q, miss_line_d;
  logic [15:0]       hit_cnt_q, hit_cnt_d;
  logic [15:0]       miss_cnt_q, miss_cnt_d;
  logic [LINES-1:0]  valid_q, valid_d;

  // Line storage (not reset; guarded by valid_q)
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [63:0]       data_q [LINES];

  // PC decomposition
  logic [TAG_W-1:0]      pc_tag;
  logic [INDEX_BITS-1:0] pc_idx;
  logic [1:0]            pc_off;
  logic                  hit;
  logic [63:0]           line_data;

  // Refill write port
  logic                  fill_we;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;

  assign pc_tag   = PC[15:INDEX_BITS+2];
  assign pc_idx   = PC[INDEX_BITS+1:2];
  assign pc_off   = PC[1:0];
  assign fill_idx = miss_line_q[INDEX_BITS-1:0];
  assign fill_tag = miss_line_q[13:INDEX_BITS];
  assign fill_we  = (state_q == S_WAIT) && mem.MemAck;

  // Combinational lookup and word select
  always_comb begin
    hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    line_data = data_q[pc_idx];
    case (pc_off)
      2'd0:    Inst = line_data[15:0];
      2'd1:    Inst = line_data[31:16];
      2'd2:    Inst = line_data[47:32];
      default: Inst = line_data[63:48];
    endcase
  end

  // Pipeline-facing status; busy covers the miss cycle plus the whole refill
  always_comb begin
    InstValid     = ReadEn && hit && (state_q == S_IDLE);
    InstCacheBusy = (state_q != S_IDLE) || (ReadEn && !hit);
  end

  // Next-state, counters and valid-bit update
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    miss_line_d = miss_line_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    valid_d     = valid_q;
    case (state_q)
      S_IDLE: begin
        if (ReadEn && hit && FetchTaken && (hit_cnt_q != 16'hFFFF))
          hit_cnt_d = hit_cnt_q + 16'd1;
        if (ReadEn && !hit) begin
          miss_line_d = {pc_tag, pc_idx};
          mem_req_d   = 1'b1;
          state_d     = S_WAIT;
          if (miss_cnt_q != 16'hFFFF)
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        if (mem.MemAck) begin
          valid_d[fill_idx] = 1'b1;
          mem_req_d         = 1'b0;
          state_d           = S_FILL;
        end
      end
      S_FILL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Control registers; reset aborts any refill in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      miss_line_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      miss_line_q <= miss_line_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      valid_q     <= valid_d;
    end
  end

  // Tag and data arrays written only by an acknowledged refill
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem.MemData;
    end
  end

  assign mem.MemReadReq = mem_req_q;
  assign mem.MemAddr    = miss_line_q;
  assign HitCount       = hit_cnt_q;
  assign MissCount      = miss_cnt_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_inst_cache.sv
// Bench for inst_cache: directed scenarios plus a randomized run, all
// checked every cycle against a transaction-level model of the cache.
module tb_inst_cache;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        ReadEn = 1'b0;
  logic        FetchTaken = 1'b0;
  logic [15:0] PC = 16'h0;
  logic [15:0] Inst;
  logic        InstValid;
  logic        InstCacheBusy;
  logic [15:0] HitCount;
  logic [15:0] MissCount;
  logic [1:0]  state_dbg;

  inst_cache_if mem_if ();

  always #5 clk = ~clk;

  inst_cache #(.INDEX_BITS(2), .WORD_WIDTH(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ReadEn        (ReadEn),
    .PC            (PC),
    .FetchTaken    (FetchTaken),
    .Inst          (Inst),
    .InstValid     (InstValid),
    .InstCacheBusy (InstCacheBusy),
    .HitCount      (HitCount),
    .MissCount     (MissCount),
    .state_dbg     (state_dbg),
    .mem           (mem_if)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory responder ----------------
  logic [63:0] mem_img [256];
  int          fixed_delay = 0;
  int          wait_cnt    = 0;
  int          cur_delay   = 1;
  bit          req_acked   = 0;
  bit          inject_ack  = 0;

  initial begin
    mem_if.MemAck  = 1'b0;
    mem_if.MemData = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_if.MemAck = 1'b0;
      if (inject_ack) begin
        inject_ack     = 0;
        mem_if.MemAck  = 1'b1;
        mem_if.MemData = {$urandom, $urandom};
      end else if (mem_if.MemReadReq && !req_acked) begin
        if (wait_cnt == 0)
          cur_delay = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 4);
        wait_cnt++;
        if (wait_cnt >= cur_delay) begin
          mem_if.MemAck  = 1'b1;
          mem_if.MemData = mem_img[mem_if.MemAddr[7:0]];
          req_acked      = 1;
        end
      end else if (!mem_if.MemReadReq) begin
        wait_cnt  = 0;
        req_acked = 0;
      end
    end
  end

  // ---------------- behavioural model ----------------
  // A cache of 4 lines plus one outstanding refill transaction: the refill is
  // "active" from the miss until the cycle after its data arrives.
  bit          m_valid [4];
  logic [11:0] m_tag   [4];
  logic [63:0] m_data  [4];
  bit          r_active, r_acked;
  logic [13:0] r_line;
  logic [15:0] m_hits, m_misses;

  function automatic bit m_hit(input logic [15:0] pc);
    return m_valid[pc[3:2]] && (m_tag[pc[3:2]] == pc[15:4]);
  endfunction

  function automatic logic [15:0] m_word(input logic [15:0] pc);
    logic [63:0] l;
    l = m_data[pc[3:2]];
    return l[pc[1:0]*16 +: 16];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      r_active = 0;
      r_acked  = 0;
      r_line   = '0;
      m_hits   = '0;
      m_misses = '0;
    end else if (!r_active) begin
      if (ReadEn && m_hit(PC) && FetchTaken && m_hits != 16'hFFFF) m_hits = m_hits + 1;
      if (ReadEn && !m_hit(PC)) begin
        r_active = 1;
        r_acked  = 0;
        r_line   = PC[15:2];
        if (m_misses != 16'hFFFF) m_misses = m_misses + 1;
      end
    end else if (!r_acked) begin
      if (mem_if.MemAck) begin
        m_valid[r_line[1:0]] = 1;
        m_tag[r_line[1:0]]   = r_line[13:2];
        m_data[r_line[1:0]]  = mem_if.MemData;
        r_acked = 1;
      end
    end else begin
      r_active = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit h;
    bit e_valid;
    h       = m_hit(PC);
    e_valid = !r_active && ReadEn && h;
    chk("busy", InstCacheBusy, r_active || (ReadEn && !h));
    chk("inst_valid", InstValid, e_valid);
    chk("mem_req", mem_if.MemReadReq, r_active && !r_acked);
    chk("mem_addr", mem_if.MemAddr, r_line);
    chk("hit_count", HitCount, m_hits);
    chk("miss_count", MissCount, m_misses);
    if (e_valid) chk("inst", Inst, m_word(PC));
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs until InstValid (left at that cycle's negedge); counts busy cycles.
  task automatic wait_hit(output int busy_n, output logic [13:0] first_addr, output bit ok);
    bit seen;
    seen = 0;
    busy_n = 0;
    ok = 0;
    first_addr = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (InstCacheBusy) busy_n++;
      if (mem_if.MemReadReq && !seen) begin
        seen = 1;
        first_addr = mem_if.MemAddr;
      end
      if (InstValid) begin
        ok = 1;
        break;
      end
      next_cycle();
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_hit: no InstValid within 40 cycles at %0t", $time);
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int          busy_n;
    logic [13:0] fa;
    bit          ok;
    logic [15:0] pcs  [3];
    logic [15:0] exps [3];
    logic [13:0] addr_q [$];
    logic [15:0] h0;
    bit          prev_req;
    bit          got;

    foreach (mem_img[i]) mem_img[i] = {$urandom, $urandom};
    mem_img[1] = 64'h4444_3333_2222_1111;

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_req", mem_if.MemReadReq, 1'b0);
    chk("rst_addr", mem_if.MemAddr, 14'h0);
    chk("rst_hits", HitCount, 16'h0);
    chk("rst_misses", MissCount, 16'h0);
    chk("rst_state", state_dbg, 2'd0);

    // 1: cold miss, ack on the 3rd request cycle
    fixed_delay = 3;
    next_cycle();
    ReadEn = 1'b1; PC = 16'h0005; FetchTaken = 1'b1;
    wait_hit(busy_n, fa, ok);
    chk("t1_busy_cycles", busy_n, 5);
    chk("t1_addr", fa, 14'h0001);
    chk("t1_inst", Inst, 16'h2222);
    chk("t1_misses", MissCount, 16'd1);

    // 2: line reuse
    pcs[0] = 16'h0004; pcs[1] = 16'h0006; pcs[2] = 16'h0007;
    exps[0] = 16'h1111; exps[1] = 16'h3333; exps[2] = 16'h4444;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      PC = pcs[i];
      @(negedge clk);
      chk("t2_valid", InstValid, 1'b1);
      chk("t2_inst", Inst, exps[i]);
      chk("t2_busy", InstCacheBusy, 1'b0);
    end
    next_cycle();
    ReadEn = 1'b0;
    @(negedge clk);
    chk("t2_hits", HitCount, 16'd4);

    // 3: conflict eviction on index 0
    fixed_delay = 0;
    next_cycle();
    ReadEn = 1'b1; PC = 16'h0010;
    wait_hit(busy_n, fa, ok);
    chk("t3_miss_a", busy_n > 0, 1'b1);
    next_cycle();
    PC = 16'h0000;
    wait_hit(busy_n, fa, ok);
    chk("t3_miss_b", busy_n > 0, 1'b1);
    chk("t3_misses", MissCount, 16'd3);
    next_cycle();
    PC = 16'h0010;
    @(negedge clk);
    chk("t3_remiss_busy", InstCacheBusy, 1'b1);
    chk("t3_remiss_valid", InstValid, 1'b0);
    next_cycle();
    wait_hit(busy_n, fa, ok);
    chk("t3_misses_end", MissCount, 16'd4);

    // 4: redirect during WAIT
    fixed_delay = 3;
    next_cycle();
    PC = 16'h0020;
    prev_req = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (mem_if.MemReadReq && !prev_req) addr_q.push_back(mem_if.MemAddr);
      prev_req = mem_if.MemReadReq;
      if (InstValid) begin
        got = 1;
        chk("t4_valid_pc", PC, 16'h0044);
      end else begin
        next_cycle();
        if (i == 1) PC = 16'h0044;
      end
    end
    chk("t4_done", got, 1'b1);
    chk("t4_nreq", addr_q.size(), 2);
    if (addr_q.size() == 2) begin
      chk("t4_addr0", addr_q[0], 14'h0008);
      chk("t4_addr1", addr_q[1], 14'h0011);
    end
    chk("t4_inst", Inst, mem_img[8'h11][15:0]);
    next_cycle();
    PC = 16'h0020;
    @(negedge clk);
    chk("t4_line8_hit", InstValid, 1'b1);
    chk("t4_line8_inst", Inst, mem_img[8'h08][15:0]);

    // 5: stall accounting
    next_cycle();
    FetchTaken = 1'b0;
    h0 = m_hits;
    repeat (3) next_cycle();
    next_cycle();
    FetchTaken = 1'b1;
    next_cycle();
    ReadEn = 1'b0;
    @(negedge clk);
    chk("t5_hits", HitCount, h0 + 16'd1);

    // 6: reset during WAIT, then a stray ack
    fixed_delay = 4;
    next_cycle();
    ReadEn = 1'b1; PC = 16'h0100;
    @(negedge clk);
    chk("t6_miss", InstCacheBusy, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("t6_req", mem_if.MemReadReq, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_req_drop", mem_if.MemReadReq, 1'b0);
    chk("t6_misses_clr", MissCount, 16'd0);
    chk("t6_hits_clr", HitCount, 16'd0);
    ReadEn = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    inject_ack = 1;
    next_cycle();
    @(negedge clk);
    chk("t6_stray_busy", InstCacheBusy, 1'b0);
    chk("t6_stray_req", mem_if.MemReadReq, 1'b0);
    chk("t6_stray_state", state_dbg, 2'd0);
    next_cycle();
    ReadEn = 1'b1; PC = 16'h0100;
    wait_hit(busy_n, fa, ok);
    chk("t6_busy_cycles", busy_n, 6);
    chk("t6_addr", fa, 14'h0040);
    chk("t6_misses", MissCount, 16'd1);
    chk("t6_hits", HitCount, 16'd0);

    // Randomized traffic: small PC window for hits, conflicts and redirects
    fixed_delay = 0;
    for (int i = 0; i < 2000; i++) begin
      next_cycle();
      ReadEn     = ($urandom_range(0, 9) < 8);
      PC         = 16'($urandom_range(0, 63));
      FetchTaken = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) inject_ack = 1;
    end
    next_cycle();
    ReadEn = 1'b0;
    repeat (8) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
